// File: rtl/score_tracker.sv
// score_tracker
//   Keeps the running game state downstream of the note hit/miss checker.
//   Each rising edge of check_done is one judgement. A hit grows the combo,
//   raises the multiplier every MULT_STEP consecutive hits and adds the
//   multiplier in force before the hit to the score. A miss clears the combo
//   and costs a life, and losing the last life ends the game.
//
//   Ports
//     clk          system clock
//     reset        synchronous active-high reset, overrides everything
//     start        begin/restart a game (level, sampled every clock)
//     check_done   checker result valid; may stay high for several cycles
//     hit, miss    judgement, valid with check_done (miss wins if both set)
//     score        accumulated score, saturating
//     combo        consecutive hits since the last miss, saturating
//     multiplier   current score multiplier, 1..MAX_MULT
//     lives        remaining lives
//     playing      high while a game is running
//     game_over    high once the last life is lost
//     update_pulse one-cycle strobe following each applied judgement
module score_tracker #(
  parameter int SCORE_W   = 10,
  parameter int COMBO_W   = 7,
  parameter int LIVES     = 3,
  parameter int MULT_STEP = 4,
  parameter int MAX_MULT  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               check_done,
  input  logic               hit,
  input  logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [2:0]         multiplier,
  output logic [1:0]         lives,
  output logic               playing,
  output logic               game_over,
  output logic               update_pulse
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_t             state;
  logic               check_done_q;
  logic               ev;
  logic [COMBO_W-1:0] combo_n;
  logic [2:0]         mult_n;

  function automatic logic [COMBO_W-1:0] sat_inc_combo(input logic [COMBO_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [2:0] mult_for(input logic [COMBO_W-1:0] c);
    int m;
    m = 1 + int'(c) / MULT_STEP;
    if (m > MAX_MULT) m = MAX_MULT;
    return 3'(m);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add_score(input logic [SCORE_W-1:0] s,
                                                       input logic [2:0]         m);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + (SCORE_W+1)'(m);
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

  // Only the rising edge of check_done counts, so a held level is one judgement.
  always_comb begin
    ev      = check_done & ~check_done_q;
    combo_n = sat_inc_combo(combo);
    mult_n  = mult_for(combo_n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      score        <= '0;
      combo        <= '0;
      multiplier   <= 3'd1;
      lives        <= LIVES_INIT;
      playing      <= 1'b0;
      game_over    <= 1'b0;
      update_pulse <= 1'b0;
      check_done_q <= 1'b0;
    end else begin
      check_done_q <= check_done;
      update_pulse <= 1'b0;
      // start reloads from any state and takes precedence over a judgement
      if (start) begin
        state      <= PLAY;
        score      <= '0;
        combo      <= '0;
        multiplier <= 3'd1;
        lives      <= LIVES_INIT;
        playing    <= 1'b1;
        game_over  <= 1'b0;
      end else if (state == PLAY && ev) begin
        update_pulse <= 1'b1;
        if (miss) begin
          combo      <= '0;
          multiplier <= 3'd1;
          if (lives <= 2'd1) begin
            lives     <= 2'd0;
            state     <= OVER;
            playing   <= 1'b0;
            game_over <= 1'b1;
          end else begin
            lives <= lives - 2'd1;
          end
        end else if (hit) begin
          combo      <= combo_n;
          multiplier <= mult_n;
          score      <= sat_add_score(score, multiplier);
        end
      end
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker
//   Drives two score_tracker instances with the same directed judgement
//   sequence: one with default widths and one with narrow score/combo so
//   that saturation is reached quickly. A game-level model tracks both and
//   is compared against every output each cycle; literal values pin the
//   model at the interesting points of each scenario.
module tb_score_tracker;

  logic clk = 1'b0;
  logic reset, start, check_done, hit, miss;

  logic [9:0] score0;
  logic [6:0] combo0;
  logic [2:0] mult0;
  logic [1:0] lives0;
  logic       play0, over0, pulse0;

  logic [3:0] score1;
  logic [2:0] combo1;
  logic [2:0] mult1;
  logic [1:0] lives1;
  logic       play1, over1, pulse1;

  int n_chk  = 0;
  int n_fail = 0;
  bit armed  = 1'b0;
  int npulse = 0;
  int np0;

  always #5 clk = ~clk;

  score_tracker u_dut0 (
    .clk(clk), .reset(reset), .start(start), .check_done(check_done),
    .hit(hit), .miss(miss), .score(score0), .combo(combo0),
    .multiplier(mult0), .lives(lives0), .playing(play0),
    .game_over(over0), .update_pulse(pulse0)
  );

  score_tracker #(.SCORE_W(4), .COMBO_W(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .check_done(check_done),
    .hit(hit), .miss(miss), .score(score1), .combo(combo1),
    .multiplier(mult1), .lives(lives1), .playing(play1),
    .game_over(over1), .update_pulse(pulse1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Game-level model: one entry per instance
  int m_score[2], m_combo[2], m_mult[2], m_lives[2];
  bit m_play[2], m_over[2], m_pulse[2];
  bit m_cdq;
  int smax[2] = '{1023, 15};
  int cmax[2] = '{127, 7};

  always @(posedge clk) begin
    bit ev;
    int add;
    ev = check_done && !m_cdq;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_score[i] = 0; m_combo[i] = 0; m_mult[i] = 1; m_lives[i] = 3;
        m_play[i]  = 0; m_over[i]  = 0; m_pulse[i] = 0;
      end else begin
        m_pulse[i] = 0;
        if (start) begin
          m_score[i] = 0; m_combo[i] = 0; m_mult[i] = 1; m_lives[i] = 3;
          m_play[i]  = 1; m_over[i]  = 0;
        end else if (m_play[i] && ev) begin
          m_pulse[i] = 1;
          if (miss) begin
            m_combo[i] = 0;
            m_mult[i]  = 1;
            m_lives[i] = m_lives[i] - 1;
            if (m_lives[i] == 0) begin
              m_play[i] = 0;
              m_over[i] = 1;
            end
          end else if (hit) begin
            add        = m_mult[i];
            m_combo[i] = (m_combo[i] < cmax[i]) ? m_combo[i] + 1 : cmax[i];
            m_mult[i]  = 1 + m_combo[i] / 4;
            if (m_mult[i] > 4) m_mult[i] = 4;
            m_score[i] = m_score[i] + add;
            if (m_score[i] > smax[i]) m_score[i] = smax[i];
          end
        end
      end
    end
    m_cdq = reset ? 1'b0 : check_done;
  end

  always @(negedge clk) begin
    if (armed) begin
      check("score0", 32'(score0), m_score[0]);
      check("combo0", 32'(combo0), m_combo[0]);
      check("mult0",  32'(mult0),  m_mult[0]);
      check("lives0", 32'(lives0), m_lives[0]);
      check("play0",  32'(play0),  32'(m_play[0]));
      check("over0",  32'(over0),  32'(m_over[0]));
      check("pulse0", 32'(pulse0), 32'(m_pulse[0]));
      check("score1", 32'(score1), m_score[1]);
      check("combo1", 32'(combo1), m_combo[1]);
      check("mult1",  32'(mult1),  m_mult[1]);
      check("lives1", 32'(lives1), m_lives[1]);
      check("play1",  32'(play1),  32'(m_play[1]));
      check("over1",  32'(over1),  32'(m_over[1]));
      check("pulse1", 32'(pulse1), 32'(m_pulse[1]));
      if (pulse0) npulse++;
    end
  end

  task automatic judge(input bit h, input bit m, input int hold);
    check_done = 1'b1; hit = h; miss = m;
    repeat (hold) @(negedge clk);
    check_done = 1'b0; hit = 1'b0; miss = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; check_done = 1'b0; hit = 1'b0; miss = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    armed = 1'b1;
    check("rst_score", 32'(score0), 0);
    check("rst_lives", 32'(lives0), 3);
    check("rst_mult",  32'(mult0),  1);
    check("rst_play",  32'(play0),  0);
    check("rst_over",  32'(over0),  0);

    // reset in the middle of a game
    start_game();
    judge(0, 1, 3); judge(0, 1, 3);
    for (int k = 0; k < 3; k++) judge(1, 0, 3);
    check("mid_lives", 32'(lives0), 1);
    check("mid_score", 32'(score0), 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_score", 32'(score0), 0);
    check("mrst_lives", 32'(lives0), 3);
    check("mrst_mult",  32'(mult0),  1);
    check("mrst_play",  32'(play0),  0);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_over_start", 32'(play0), 0);

    // five hits
    start_game();
    np0 = npulse;
    for (int k = 0; k < 5; k++) judge(1, 0, 3);
    check("h5_combo", 32'(combo0), 5);
    check("h5_mult",  32'(mult0),  2);
    check("h5_score", 32'(score0), 6);
    check("h5_pulses", 32'(npulse - np0), 5);

    // eight hits then a miss
    start_game();
    for (int k = 0; k < 8; k++) judge(1, 0, 3);
    check("h8_score", 32'(score0), 12);
    check("h8_combo", 32'(combo0), 8);
    check("h8_mult",  32'(mult0),  3);
    judge(0, 1, 3);
    check("m1_combo", 32'(combo0), 0);
    check("m1_mult",  32'(mult0),  1);
    check("m1_lives", 32'(lives0), 2);
    check("m1_score", 32'(score0), 12);

    // run out of lives
    start_game();
    judge(0, 1, 3);
    check("go_lives_a", 32'(lives0), 2);
    judge(0, 1, 3);
    check("go_lives_b", 32'(lives0), 1);
    judge(0, 1, 3);
    check("go_lives_c", 32'(lives0), 0);
    check("go_over",    32'(over0),  1);
    check("go_play",    32'(play0),  0);
    np0 = npulse;
    judge(1, 0, 3);
    check("go_frozen_score", 32'(score0), 0);
    check("go_frozen_pulse", 32'(npulse - np0), 0);
    start_game();
    check("rs_play",  32'(play0),  1);
    check("rs_lives", 32'(lives0), 3);
    check("rs_score", 32'(score0), 0);
    check("rs_over",  32'(over0),  0);

    // hit and miss together, then an empty judgement
    judge(1, 0, 3); judge(1, 0, 3);
    judge(1, 1, 3);
    check("hm_lives", 32'(lives0), 2);
    check("hm_combo", 32'(combo0), 0);
    check("hm_score", 32'(score0), 2);
    np0 = npulse;
    judge(0, 0, 3);
    check("emp_pulse", 32'(npulse - np0), 1);
    check("emp_score", 32'(score0), 2);
    check("emp_lives", 32'(lives0), 2);

    // a long check_done level is a single judgement
    np0 = npulse;
    judge(1, 0, 10);
    check("long_pulse", 32'(npulse - np0), 1);
    check("long_combo", 32'(combo0), 1);
    check("long_score", 32'(score0), 3);

    // start wins over a judgement edge in the same cycle
    check_done = 1'b1; hit = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_done = 1'b0; hit = 1'b0;
    @(negedge clk);
    check("sov_score", 32'(score0), 0);
    check("sov_combo", 32'(combo0), 0);

    // saturation on the narrow instance
    start_game();
    for (int k = 0; k < 12; k++) judge(1, 0, 3);
    check("sat_score1", 32'(score1), 15);
    check("sat_combo1", 32'(combo1), 7);
    check("sat_mult1",  32'(mult1),  2);
    check("h12_score0", 32'(score0), 24);
    check("h12_combo0", 32'(combo0), 12);
    check("h12_mult0",  32'(mult0),  4);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
